// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: widths, arbiter state encoding and request bundle shared by the SPI memory arbiter.
package spi_mem_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/spi_mem_rtag.sv
// spi_mem_rtag: one-deep read-tag pipeline that returns rvalid to whichever requester issued the read.
module spi_mem_rtag (
    input  logic clk,
    input  logic reset,
    input  logic rd_i,
    input  logic owner_i,
    output logic r0_rvalid_o,
    output logic r1_rvalid_o
);
    logic [1:0] rv_q, rv_d;

    assign rv_d = rd_i ? (owner_i ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) rv_q <= 2'b00;
        else rv_q <= rv_d;
    end

    assign r0_rvalid_o = rv_q[0];
    assign r1_rvalid_o = rv_q[1];
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: two-requester arbiter/sequencer for the shared registered-read SPI data RAM.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin ties and MAX_HOLD preemption of both owners.
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e     state_q, state_d, other;
    logic [3:0] hold_q, hold_d, hold_inc;
    req_t       r0, r1, own;
    logic       owned, own_id, oth_req, issue, rd_issue, preempt, tie_pick;

    assign r0       = {r0_req, r0_we, r0_addr, r0_wdata};
    assign r1       = {r1_req, r1_we, r1_addr, r1_wdata};
    assign owned    = state_q != IDLE;
    assign own_id   = state_q == OWN1;
    assign own      = own_id ? r1 : r0;
    assign oth_req  = own_id ? r0_req : r1_req;
    assign other    = own_id ? OWN0 : OWN1;
    assign issue    = owned && own.req && !reset;
    assign rd_issue = issue && !own.we;
    // Count includes this cycle's access so the owner gets exactly MAX_HOLD accesses before handing over
    assign hold_inc = (issue && hold_q != 4'(MAX_HOLD)) ? hold_q + 4'd1 : hold_q;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_d = state_d == OWN0 ? 1'b0 : state_d == OWN1 ? 1'b1 : last_q;
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else last_q <= last_d;
    end
    assign preempt  = 1'b1;
    assign tie_pick = ~last_q;
`else
    assign preempt  = own_id;
    assign tie_pick = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!owned)
            state_d = (r0_req && r1_req) ? (tie_pick ? OWN1 : OWN0) : r0_req ? OWN0 : r1_req ? OWN1 : IDLE;
        else if (!own.req)
            state_d = oth_req ? other : IDLE;
        else if (preempt && oth_req && hold_inc == 4'(MAX_HOLD))
            state_d = other;
        hold_d = (state_d != state_q) ? 4'd0 : hold_inc;
    end

    always_comb begin
        r0_gnt    = state_q == OWN0;
        r1_gnt    = own_id;
        mem_we    = issue && own.we;
        mem_addr  = owned ? own.addr : '0;
        mem_wdata = owned ? own.wdata : '0;
        rdata     = mem_rdata;
    end

    spi_mem_rtag u_rtag (
        .clk        (clk),
        .reset      (reset),
        .rd_i       (rd_issue),
        .owner_i    (own_id),
        .r0_rvalid_o(r0_rvalid),
        .r1_rvalid_o(r1_rvalid)
    );
endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Two-port arbiter and sequencer for the 128-byte SPI data memory. It shares one registered-read RAM between requester 0 (the SPI transaction FSM) and requester 1 (the local host/debug port). It issues one access per cycle to the owner's address, returns read data with fixed latency, and bounds each owner's tenure so neither side starves.

## Interface
- ADDR_W, 7, memory word address width (128 locations)
- DATA_W, 8, byte width
- MAX_HOLD, 4, maximum consecutive accesses an owner may issue while the other requester waits (1..15)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- r0_req, r1_req  in  1  access request, held high until the access is granted and issued
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  ADDR_W  word address
- r0_wdata, r1_wdata  in  DATA_W  write data
- r0_gnt, r1_gnt  out  1  registered grant; an access is issued in every cycle where req && gnt
- r0_rvalid, r1_rvalid  out  1  read data valid for that requester
- rdata  out  DATA_W  shared read data, qualified by rX_rvalid
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented

## Operation
- States: IDLE, OWN0, OWN1. Reset puts the block in IDLE.
- Reset values: gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, hold_cnt=0, last_owner=1.
- IDLE:
  - One requester high: move to OWNx.
  - Both high: arbitration policy decides (see Configuration).
  - Neither high: stay in IDLE.
- OWNx:
  - gnt_x=1. The mem_* outputs mux combinationally from requester x.
  - mem_we = rx_req & rx_we & gnt_x.
  - Each issued access increments hold_cnt, saturating at MAX_HOLD.
- Leaving OWNx:
  - rx_req low: go to OWNy if ry_req is high, else IDLE.
  - hold_cnt==MAX_HOLD and ry_req high: go to OWNy even if rx_req stays high. The preempted requester keeps req high and is re-granted later.
  - hold_cnt==MAX_HOLD and ry_req low: stay in OWNx and keep issuing.
- Any change of owner clears hold_cnt and sets last_owner.
- Read return:
  - A read issued in cycle N sets rx_rvalid in N+1, tagged to the issuing requester.
  - rdata = mem_rdata.
  - Back-to-back reads give back-to-back rvalid.
- Owner switch:
  - The tag pipeline means a read issued by the old owner in its last cycle still returns to the old owner, even while the new owner holds gnt.
  - The first access of the new owner is issued the cycle after the switch. No overlap is possible.
- Reset mid-operation: any in-flight rvalid is dropped, gnt clears, and no mem_we pulse is generated in the reset cycle.
- Addresses pass through unmodified. The block does no address arithmetic or wrap.

## Timing
- Request latency from IDLE: req high in cycle N gives gnt high in N+1, access issued in N+1, rvalid (read) in N+2.
- While owned: one access per cycle, zero bubbles.
- Switch latency: the decision is made in the last owned cycle. The other requester's gnt rises the next cycle and gnt_x falls in the same cycle. One gnt is high at most at any time.
- Requester rule: hold addr, we and wdata stable while req is high and gnt is low.

## Configuration
- SPI_ARB_ROUND_ROBIN_EN defined:
  - In IDLE with both requesting, grant the requester that is not last_owner. After reset, requester 0 wins the first tie.
  - The MAX_HOLD preemption applies to both owners.
- Not defined (fixed priority):
  - Requester 0 always wins ties.
  - The MAX_HOLD preemption applies only to owner 1. Owner 0 keeps the grant until r0_req drops.

## Structure
- Shared package spi_mem_pkg holds:
  - Constants: ADDR_W, DATA_W.
  - State enum: IDLE, OWN0, OWN1.
  - A typedef for the request bundle: req, we, addr, wdata.
- One sub-module is natural: spi_mem_rtag. It is a 1-deep read-tag pipeline producing r0_rvalid and r1_rvalid from the issued-read strobe and the owner ID.
- The RAM stays outside the block.

## Test plan
- Reset then single write: r1 writes 0xA5 to addr 0x10, then reads 0x10. Expect mem_we for 1 cycle, r1_rvalid 2 cycles after req with rdata=0xA5.
- Tie from IDLE: r0 and r1 request in the same cycle. Expect r0_gnt first in both builds. With SPI_ARB_ROUND_ROBIN_EN, the next tie goes to r1.
- Hold limit: r0 streams 8 reads while r1 requests, MAX_HOLD=4. With the macro, r0 gets 4 accesses, then r1 is granted, then r0 resumes. Without it, r0 completes all 8 first.
- Switch with an in-flight read: r1's last access is a read at addr 0x7F while r0 waits. Expect r1_rvalid in the cycle r0_gnt rises, and r0_rvalid stays low.
- Full-rate back-to-back: r0 issues write/read alternating across addresses 0x00..0x7F. Expect zero bubbles and each read returns the preceding write's data.
- Reset mid-burst: assert reset during an r1 read. Expect all outputs 0 in the next cycle, no rvalid, state IDLE, and last_owner=1.
